bsg_manycore_edge_loader: RTL and testbench

SPMD program loader that sits directly upstream of the manycore array on one edge input port. On `start_i` it reads a program image from an external synchronous ROM and injects one remote-store packet per word per tile into the array. The same image is broadcast to every tile. Once all stores are injected, it sends one unfreeze packet per tile. Its output drives one array edge input (data/v/ready) with the array's packet format.

---
 rtl/bsg_manycore_pkg.sv | 28 ++
 rtl/bsg_manycore_tile_iter.sv | 48 ++++
 rtl/bsg_manycore_edge_loader.sv | 186 ++++++++++++++++++
 tb/tb_bsg_manycore_edge_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore definitions: packet op/mask encodings, loader FSM states and
// width helpers used by the array edge devices.
package bsg_manycore_pkg;

  typedef enum logic [1:0] {
    e_op_load  = 2'b00,
    e_op_store = 2'b01
  } op_e;

  localparam int          op_width_gp     = 2;
  localparam int          mask_width_gp   = 4;
  localparam logic [3:0]  store_mask_gp   = 4'b1111;

  typedef enum logic [2:0] {
    e_ld_idle,
    e_ld_fetch,
    e_ld_send,
    e_ld_unfreeze,
    e_ld_done
  } loader_state_e;

  // Packet layout is {data, addr, op, mask, y_cord, x_cord}; the struct itself is
  // declared in each device because its field widths follow module parameters.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_manycore_tile_iter.sv
// Nested word/x/y position counter: word is innermost, y outermost. Every field
// wraps to zero after the final position so no field ever exceeds its bound.
module bsg_manycore_tile_iter #(
  parameter int words_p      = 1,
  parameter int x_p          = 1,
  parameter int y_p          = 1,
  parameter int word_width_p = 1,
  parameter int x_width_p    = 1,
  parameter int y_width_p    = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    yumi_i,
  output logic [word_width_p-1:0] word_o,
  output logic [x_width_p-1:0]    x_o,
  output logic [y_width_p-1:0]    y_o,
  output logic                    last_o
);

  logic word_last, x_last, y_last;

  assign word_last = (word_o == word_width_p'(words_p - 1));
  assign x_last    = (x_o == x_width_p'(x_p - 1));
  assign y_last    = (y_o == y_width_p'(y_p - 1));
  assign last_o    = word_last & x_last & y_last;

  always_ff @(posedge clk_i) begin
    if (reset_i | clear_i) begin
      word_o <= '0;
      x_o    <= '0;
      y_o    <= '0;
    end else if (yumi_i) begin
      if (!word_last) begin
        word_o <= word_o + 1'b1;
      end else begin
        word_o <= '0;
        if (!x_last) begin
          x_o <= x_o + 1'b1;
        end else begin
          x_o <= '0;
          y_o <= y_last ? '0 : y_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_edge_loader.sv
// SPMD program loader on one array edge port: broadcasts a ROM image to every tile
// as remote stores, then (with BSG_MANYCORE_LOADER_UNFREEZE_EN) unfreezes each tile.
module bsg_manycore_edge_loader
  import bsg_manycore_pkg::*;
#(
  parameter int                      num_tiles_x_p     = 2,
  parameter int                      num_tiles_y_p     = 2,
  parameter int                      data_width_p      = 32,
  parameter int                      addr_width_p      = 32,
  parameter int                      load_words_p      = 4,
  parameter logic [addr_width_p-1:0] unfreeze_addr_p   = '0,
  localparam int                     x_cord_width_lp   = safe_clog2(num_tiles_x_p),
  localparam int                     y_cord_width_lp   = safe_clog2(num_tiles_y_p + 1),
  localparam int                     rom_addr_width_lp = safe_clog2(load_words_p),
  localparam int                     packet_width_lp   = op_width_gp + mask_width_gp
                                                         + x_cord_width_lp + y_cord_width_lp
                                                         + addr_width_p + data_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  output logic [rom_addr_width_lp-1:0] rom_addr_o,
  input  logic [data_width_p-1:0]      rom_data_i,
  output logic                         v_o,
  output logic [packet_width_lp-1:0]   data_o,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic                         done_o
);

  typedef struct packed {
    logic [data_width_p-1:0]    data;
    logic [addr_width_p-1:0]    addr;
    logic [op_width_gp-1:0]     op;
    logic [mask_width_gp-1:0]   mask;
    logic [y_cord_width_lp-1:0] y_cord;
    logic [x_cord_width_lp-1:0] x_cord;
  } packet_s;

  loader_state_e state_r, state_n;

  logic                         iter_clear;
  logic                         store_yumi;
  logic                         store_last;
  logic [rom_addr_width_lp-1:0] store_word;
  logic [x_cord_width_lp-1:0]   store_x;
  logic [y_cord_width_lp-1:0]   store_y;

  logic                         entry_r;
  logic [data_width_p-1:0]      rom_data_r;
  logic [data_width_p-1:0]      send_data;
  packet_s                      pkt;

  bsg_manycore_tile_iter #(
    .words_p      (load_words_p),
    .x_p          (num_tiles_x_p),
    .y_p          (num_tiles_y_p),
    .word_width_p (rom_addr_width_lp),
    .x_width_p    (x_cord_width_lp),
    .y_width_p    (y_cord_width_lp)
  ) store_iter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (iter_clear),
    .yumi_i  (store_yumi),
    .word_o  (store_word),
    .x_o     (store_x),
    .y_o     (store_y),
    .last_o  (store_last)
  );

`ifdef BSG_MANYCORE_LOADER_UNFREEZE_EN
  logic                       unf_yumi;
  logic                       unf_last;
  logic                       unf_word_unused;
  logic [x_cord_width_lp-1:0] unf_x;
  logic [y_cord_width_lp-1:0] unf_y;

  bsg_manycore_tile_iter #(
    .words_p      (1),
    .x_p          (num_tiles_x_p),
    .y_p          (num_tiles_y_p),
    .word_width_p (1),
    .x_width_p    (x_cord_width_lp),
    .y_width_p    (y_cord_width_lp)
  ) unfreeze_iter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (iter_clear),
    .yumi_i  (unf_yumi),
    .word_o  (unf_word_unused),
    .x_o     (unf_x),
    .y_o     (unf_y),
    .last_o  (unf_last)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ld_idle;
      entry_r <= 1'b0;
    end else begin
      state_r <= state_n;
      entry_r <= (state_r == e_ld_fetch);
    end
  end

  // The ROM word arrives in the first SEND cycle; keep it so the packet stays
  // stable while the array back-pressures.
  always_ff @(posedge clk_i) begin
    if (entry_r) rom_data_r <= rom_data_i;
  end

  assign send_data = entry_r ? rom_data_i : rom_data_r;

  always_comb begin
    state_n    = state_r;
    iter_clear = 1'b0;
    store_yumi = 1'b0;
`ifdef BSG_MANYCORE_LOADER_UNFREEZE_EN
    unf_yumi   = 1'b0;
`endif
    case (state_r)
      e_ld_idle, e_ld_done: begin
        if (start_i) begin
          state_n    = e_ld_fetch;
          iter_clear = 1'b1;
        end
      end
      e_ld_fetch: state_n = e_ld_send;
      e_ld_send: begin
        if (ready_i) begin
          store_yumi = 1'b1;
`ifdef BSG_MANYCORE_LOADER_UNFREEZE_EN
          state_n    = store_last ? e_ld_unfreeze : e_ld_fetch;
`else
          state_n    = store_last ? e_ld_done : e_ld_fetch;
`endif
        end
      end
`ifdef BSG_MANYCORE_LOADER_UNFREEZE_EN
      e_ld_unfreeze: begin
        if (ready_i) begin
          unf_yumi = 1'b1;
          if (unf_last) state_n = e_ld_done;
        end
      end
`endif
      default: state_n = e_ld_idle;
    endcase
  end

  always_comb begin
    pkt.op   = e_op_store;
    pkt.mask = store_mask_gp;
    if (state_r == e_ld_send) begin
      pkt.data   = send_data;
      pkt.addr   = addr_width_p'(store_word);
      pkt.y_cord = store_y;
      pkt.x_cord = store_x;
    end else begin
      pkt.data   = '0;
      pkt.addr   = unfreeze_addr_p;
`ifdef BSG_MANYCORE_LOADER_UNFREEZE_EN
      pkt.y_cord = unf_y;
      pkt.x_cord = unf_x;
`else
      pkt.y_cord = store_y;
      pkt.x_cord = store_x;
`endif
    end
  end

  always_comb begin
    v_o = (state_r == e_ld_send);
`ifdef BSG_MANYCORE_LOADER_UNFREEZE_EN
    v_o = v_o | (state_r == e_ld_unfreeze);
`endif
  end

  assign data_o     = v_o ? pkt : '0;
  assign rom_addr_o = store_word;
  assign busy_o     = (state_r != e_ld_idle) && (state_r != e_ld_done);
  assign done_o     = (state_r == e_ld_done);

endmodule

// File: tb/tb_bsg_manycore_edge_loader.sv
// Directed bench for bsg_manycore_edge_loader: 2x2x4 load with steady and
// throttled ready, mid-load reset, restart from DONE, and a 1x1x1 instance.
module tb_bsg_manycore_edge_loader;

  localparam int PW  = 73;
  localparam int PW1 = 72;
  localparam logic [31:0] UNF = 32'h0000_0100;
`ifdef BSG_MANYCORE_LOADER_UNFREEZE_EN
  localparam int N_TOT = 20;
`else
  localparam int N_TOT = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [1:0]    rom_addr;
  logic [31:0]   rom_data;
  logic          v_o, busy_o, done_o;
  logic [PW-1:0] data_o;

  logic           start1 = 1'b0;
  logic           ready1 = 1'b1;
  logic [0:0]     rom1_addr;
  logic [31:0]    rom1_data;
  logic           v1, busy1, done1;
  logic [PW1-1:0] data1;

  int checks = 0;
  int errors = 0;

  bsg_manycore_edge_loader #(
    .num_tiles_x_p(2), .num_tiles_y_p(2), .data_width_p(32), .addr_width_p(32),
    .load_words_p(4), .unfreeze_addr_p(UNF)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  bsg_manycore_edge_loader #(
    .num_tiles_x_p(1), .num_tiles_y_p(1), .data_width_p(32), .addr_width_p(32),
    .load_words_p(1)
  ) dut1 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start1), .rom_addr_o(rom1_addr),
    .rom_data_i(rom1_data), .v_o(v1), .data_o(data1), .ready_i(ready1),
    .busy_o(busy1), .done_o(done1)
  );

  always @(posedge clk) begin
    case (rom_addr)
      2'd0: rom_data <= 32'h0000_00A0;
      2'd1: rom_data <= 32'h0000_00A1;
      2'd2: rom_data <= 32'h0000_00A2;
      default: rom_data <= 32'h0000_00A3;
    endcase
    rom1_data <= (rom1_addr == 1'b0) ? 32'h0000_005A : 32'hDEAD_BEEF;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet i of a 2x2x4 load: stores walk word, then x, then y; unfreezes follow.
  function automatic logic [PW-1:0] exp_pkt(input int i);
    int t;
    logic [31:0] d, a;
    if (i < 16) begin
      t = i / 4;
      d = 32'h0000_00A0 + 32'(i % 4);
      a = 32'(i % 4);
    end else begin
      t = i - 16;
      d = 32'h0;
      a = UNF;
    end
    return {d, a, 2'b01, 4'b1111, 2'(t / 2), 1'(t % 2)};
  endfunction

  task automatic pulse_start();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  // Consumes packets from the current cycle on; returns early when stop_at is reached.
  task automatic run_load(input string tag, input int n_exp, input bit rnd,
                          input int start_at, input int stop_at);
    int idx = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [PW-1:0] held = '0;
    while (idx < n_exp && guard < 600) begin
      if (idx == stop_at) begin
        start_i = 1'b0;
        ready_i = 1'b0;
        return;
      end
      ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      start_i = (guard == start_at);
      chk($sformatf("%s done_low", tag), 128'(done_o), 128'(1'b0));
      if (stalled) begin
        chk($sformatf("%s hold_v%0d", tag, idx), 128'(v_o), 128'(1'b1));
        chk($sformatf("%s hold_data%0d", tag, idx), 128'(data_o), 128'(held));
      end
      stalled = 1'b0;
      if (v_o) begin
        chk($sformatf("%s pkt%0d", tag, idx), 128'(data_o), 128'(exp_pkt(idx)));
        held = data_o;
        if (ready_i) idx++;
        else stalled = 1'b1;
      end
      cyc();
      guard++;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    chk($sformatf("%s count", tag), 128'(idx), 128'(n_exp));
    chk($sformatf("%s done", tag), 128'(done_o), 128'(1'b1));
    chk($sformatf("%s busy_end", tag), 128'(busy_o), 128'(1'b0));
    chk($sformatf("%s v_end", tag), 128'(v_o), 128'(1'b0));
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst v", 128'(v_o), 128'(1'b0));
    chk("rst busy", 128'(busy_o), 128'(1'b0));
    chk("rst done", 128'(done_o), 128'(1'b0));
    chk("rst rom_addr", 128'(rom_addr), 128'(2'd0));
    chk("rst data", 128'(data_o), 128'(0));
    reset_i = 1'b0;
    cyc();
    chk("idle busy", 128'(busy_o), 128'(1'b0));

    // Reset and start together: reset wins
    reset_i = 1'b1;
    start_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    start_i = 1'b0;
    chk("rst+start busy", 128'(busy_o), 128'(1'b0));
    cyc();
    chk("rst+start busy2", 128'(busy_o), 128'(1'b0));
    chk("rst+start v", 128'(v_o), 128'(1'b0));

    // 1x1 array, one word: first v_o two cycles after start
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    chk("t1 fetch v", 128'(v1), 128'(1'b0));
    chk("t1 fetch busy", 128'(busy1), 128'(1'b1));
    cyc();
    chk("t1 store v", 128'(v1), 128'(1'b1));
    chk("t1 store pkt", 128'(data1), 128'({32'h5A, 32'h0, 2'b01, 4'b1111, 1'b0, 1'b0}));
    cyc();
`ifdef BSG_MANYCORE_LOADER_UNFREEZE_EN
    chk("t1 unf v", 128'(v1), 128'(1'b1));
    chk("t1 unf pkt", 128'(data1), 128'({32'h0, 32'h0, 2'b01, 4'b1111, 1'b0, 1'b0}));
    cyc();
`endif
    chk("t1 done", 128'(done1), 128'(1'b1));
    chk("t1 v_end", 128'(v1), 128'(1'b0));

    // Full load, ready steady high
    pulse_start();
    chk("a fetch v", 128'(v_o), 128'(1'b0));
    chk("a fetch busy", 128'(busy_o), 128'(1'b1));
    chk("a fetch rom_addr", 128'(rom_addr), 128'(2'd0));
    run_load("a", N_TOT, 1'b0, -1, -1);
    cyc(); cyc();
    chk("a done_held", 128'(done_o), 128'(1'b1));
    chk("a v_quiet", 128'(v_o), 128'(1'b0));

    // Restart from DONE with throttled ready and a start pulse while busy
    pulse_start();
    run_load("b", N_TOT, 1'b1, 9, -1);

    // Reset while the 7th packet is stalled, then restart from the beginning
    pulse_start();
    run_load("c", N_TOT, 1'b0, -1, 6);
    for (int i = 0; i < 4 && !v_o; i++) cyc();
    chk("c stall v", 128'(v_o), 128'(1'b1));
    chk("c stall pkt", 128'(data_o), 128'(exp_pkt(6)));
    cyc(); cyc();
    chk("c held v", 128'(v_o), 128'(1'b1));
    chk("c held pkt", 128'(data_o), 128'(exp_pkt(6)));
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    ready_i = 1'b1;
    chk("c rst v", 128'(v_o), 128'(1'b0));
    chk("c rst busy", 128'(busy_o), 128'(1'b0));
    chk("c rst data", 128'(data_o), 128'(0));
    cyc();
    chk("c idle busy", 128'(busy_o), 128'(1'b0));
    pulse_start();
    run_load("d", N_TOT, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
